// File: rtl/inv_mix_cols_seq.sv
// Iterative AES InvMixColumns engine with a valid/ready handshake on both sides.
// COLS_PER_CYCLE (1, 2 or 4) sets how many columns are transformed per busy cycle.
// Optional build macro INV_MIX_COLS_FWD_EN adds a 'fwd' input that selects forward
// MixColumns instead of the inverse for the block being accepted.
module inv_mix_cols_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef INV_MIX_COLS_FWD_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("inv_mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NCYC = 4 / COLS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] work;
  logic [127:0] dout_r;
  logic [1:0]   cnt;
  logic         accept;
  logic         last;
  logic         in_ready_c;
`ifdef INV_MIX_COLS_FWD_EN
  logic         fwd_r;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

`ifdef INV_MIX_COLS_FWD_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
`endif

  function automatic logic [31:0] col_xform(input logic [31:0] c, input logic f);
`ifdef INV_MIX_COLS_FWD_EN
    return f ? fwd_col(c) : inv_col(c);
`else
    return f ? inv_col(c) : inv_col(c);
`endif
  endfunction

  assign last   = (cnt == 2'(NCYC - 1));
  assign accept = in_valid && in_ready_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !rst;
        if (in_valid && !rst) state_nx = BUSY;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working register, column counter and per-column result writes
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      dout_r <= '0;
      cnt    <= '0;
`ifdef INV_MIX_COLS_FWD_EN
      fwd_r  <= 1'b0;
`endif
    end else if (accept) begin
      work <= din;
      cnt  <= '0;
`ifdef INV_MIX_COLS_FWD_EN
      fwd_r <= fwd;
`endif
    end else if (state == BUSY) begin
      cnt <= cnt + 2'd1;
      // Column c belongs to busy cycle c / COLS_PER_CYCLE; write only the active group.
      for (int unsigned c = 0; c < 4; c++) begin
        if (2'(c / COLS_PER_CYCLE) == cnt)
`ifdef INV_MIX_COLS_FWD_EN
          dout_r[127-32*c -: 32] <= col_xform(work[127-32*c -: 32], fwd_r);
`else
          dout_r[127-32*c -: 32] <= col_xform(work[127-32*c -: 32], 1'b0);
`endif
      end
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = (state == DONE);
  assign dout      = dout_r;

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Self-checking bench: three engines (COLS_PER_CYCLE = 1, 2, 4) checked against a
// GF(2^8) matrix-multiply model of (Inv)MixColumns.
module tb_inv_mix_cols_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid [3];
  logic         in_ready [3];
  logic [127:0] din      [3];
  logic         out_valid[3];
  logic         out_ready[3];
  logic [127:0] dout     [3];
  logic [127:0] exp_q    [3];
`ifdef INV_MIX_COLS_FWD_EN
  logic         fwd      [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    inv_mix_cols_seq #(.COLS_PER_CYCLE(1 << k)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef INV_MIX_COLS_FWD_EN
      .fwd      (fwd[k]),
`endif
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .din      (din[k]),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .dout     (dout[k])
    );
  end

  // Generic shift-and-add GF(2^8) multiply mod 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant-matrix (Inv)MixColumns over the whole state
  function automatic logic [127:0] model(input logic [127:0] s, input bit f);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    if (f) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else   coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o ^= gmul(coef[(j - row + 4) % 4], a[j]);
        r[127 - 32*c - 8*row -: 8] = o;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output compare: whenever an engine presents a result it must match the model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && out_valid[k]) begin
        checks++;
        if (dout[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL monitor_dout inst%0d actual=%h required=%h", k, dout[k], exp_q[k]);
        end
      end
    end
  end

  // One block through engine k; called at #1 after a rising edge.
  // early=1 holds out_ready high from before acceptance (back-to-back throughput).
  task automatic run_block(input int k, input logic [127:0] data, input bit f,
                           input int hold, input bit early);
    int t;
    int lat;
    t = 0;
    while (!in_ready[k] && t < 10) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_wait", 128'(in_ready[k]), 128'd1);
    in_valid[k]  = 1'b1;
    din[k]       = data;
    out_ready[k] = early;
`ifdef INV_MIX_COLS_FWD_EN
    fwd[k] = f;
`endif
    exp_q[k] = model(data, f);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    din[k] = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MIX_COLS_FWD_EN
    fwd[k] = ~f;
`endif
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (in_ready[k]) chk("in_ready_busy", 128'(in_ready[k]), 128'd0);
    end while (!out_valid[k] && lat < 20);
    chk($sformatf("latency_inst%0d", k), 128'(lat), 128'(4 >> k));
    if (!early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_out_valid", 128'(out_valid[k]), 128'd1);
        chk("hold_in_ready", 128'(in_ready[k]), 128'd0);
      end
      out_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("post_hs_out_valid", 128'(out_valid[k]), 128'd0);
    chk("post_hs_in_ready", 128'(in_ready[k]), 128'd1);
    chk("post_hs_dout_kept", dout[k], exp_q[k]);
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] FIXED  = 128'hc6c6c6c6_01010101_00000000_ffffffff;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; din[k] = '0; exp_q[k] = '0;
`ifdef INV_MIX_COLS_FWD_EN
      fwd[k] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
      chk("rst_dout", dout[k], 128'd0);
      chk("rst_in_ready", 128'(in_ready[k]), 128'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("ready_after_rst", 128'(in_ready[k]), 128'd1);

    // Model pinned to hand-computed vectors
    chk("model_v1", model(V1_IN, 1'b0), V1_OUT);
    chk("model_fixed", model(FIXED, 1'b0), FIXED);

    // Directed vectors on every engine, checked against literal results too
    for (int k = 0; k < 3; k++) begin
      run_block(k, V1_IN, 1'b0, 0, 1'b0);
      chk($sformatf("v1_dout_inst%0d", k), dout[k], V1_OUT);
      run_block(k, FIXED, 1'b0, 1, 1'b0);
      chk($sformatf("fixed_dout_inst%0d", k), dout[k], FIXED);
    end

    // Backpressure: out_ready low for 10 cycles
    run_block(0, V1_IN, 1'b0, 10, 1'b0);

    // Reset in the second busy cycle aborts the block
    @(posedge clk); #1;
    in_valid[0] = 1'b1; din[0] = V1_IN; exp_q[0] = V1_OUT;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
    chk("abort_dout", dout[0], 128'd0);
    chk("abort_in_ready_in_rst", 128'(in_ready[0]), 128'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    run_block(0, FIXED ^ V1_IN, 1'b0, 2, 1'b0);

    // Random blocks, mixing held backpressure and back-to-back acceptance
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 8; n++) begin
        run_block(k, {$urandom, $urandom, $urandom, $urandom}, 1'b0,
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end
    end

`ifdef INV_MIX_COLS_FWD_EN
    for (int k = 0; k < 3; k++) begin
      run_block(k, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 0, 1'b0);
      chk("fwd_dout", dout[k], 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      run_block(k, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1, 1'b0);
      run_block(k, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
